// File: rtl/sevenseg_capture.sv
// Seven-segment bus capture: samples an active-low multiplexed display,
// decodes each stable digit back to a nibble and emits a complete frame.
// Ports: clk, rst_n (sync, active-low), seg_in[6:0], dp_in, dig_sel_n[NDIG-1:0]
//        frame_digits, frame_err, frame_dp, frame_ovr, frame_valid, frame_ready.
// Option: define SEVENSEG_CAPTURE_DP_EN to capture decimal points.
module sevenseg_capture #(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        seg_in,
    input  logic              dp_in,
    input  logic [NDIG-1:0]   dig_sel_n,
    output logic [4*NDIG-1:0] frame_digits,
    output logic [NDIG-1:0]   frame_err,
    output logic [NDIG-1:0]   frame_dp,
    output logic              frame_ovr,
    output logic              frame_valid,
    input  logic              frame_ready
);

`ifdef SEVENSEG_CAPTURE_DP_EN
    localparam int SW = NDIG + 8;
`else
    localparam int SW = NDIG + 7;
`endif

    localparam logic [7:0] MAX = 8'(STABLE_CYC - 1);

    logic [SW-1:0]     r_s;
    logic [7:0]        r_cnt;
    logic              r_done;
    logic [NDIG-1:0]   r_seen;
    logic [4*NDIG-1:0] r_wdig;
    logic [NDIG-1:0]   r_werr;
    logic [NDIG-1:0]   r_wdp;
    logic [4*NDIG-1:0] r_odig;
    logic [NDIG-1:0]   r_oerr;
    logic [NDIG-1:0]   r_odp;
    logic              r_ovr;
    logic              r_valid;

    logic [SW-1:0]     w_port;
    logic              w_dp_bit;
    logic              w_same;
    logic [7:0]        w_cnt_nxt;
    logic              w_done_eff;
    logic [NDIG-1:0]   w_sel;
    logic              w_onehot;
    logic [2:0]        w_idx;
    logic              w_cap;
    logic [4:0]        w_dec;
    logic [4*NDIG-1:0] w_wdig;
    logic [NDIG-1:0]   w_werr;
    logic [NDIG-1:0]   w_wdp;
    logic [NDIG-1:0]   w_seen;
    logic              w_full;
    logic              w_xfer;

`ifdef SEVENSEG_CAPTURE_DP_EN
    assign w_port   = {dig_sel_n, seg_in, dp_in};
    assign w_dp_bit = ~dp_in;
`else
    logic w_unused_dp;
    assign w_unused_dp = dp_in;
    assign w_port      = {dig_sel_n, seg_in};
    assign w_dp_bit    = 1'b0;
`endif

    // Returns {err, nibble}; anything outside the 16 glyphs is an error.
    function automatic logic [4:0] dec(input logic [6:0] s);
        case (s)
            7'h40:   dec = 5'h00;
            7'h79:   dec = 5'h01;
            7'h24:   dec = 5'h02;
            7'h30:   dec = 5'h03;
            7'h19:   dec = 5'h04;
            7'h12:   dec = 5'h05;
            7'h02:   dec = 5'h06;
            7'h78:   dec = 5'h07;
            7'h00:   dec = 5'h08;
            7'h10:   dec = 5'h09;
            7'h08:   dec = 5'h0A;
            7'h03:   dec = 5'h0B;
            7'h46:   dec = 5'h0C;
            7'h21:   dec = 5'h0D;
            7'h06:   dec = 5'h0E;
            7'h0E:   dec = 5'h0F;
            default: dec = 5'h10;
        endcase
    endfunction

    assign w_same     = (w_port == r_s);
    assign w_cnt_nxt  = !w_same ? 8'd0 :
                        (r_cnt == MAX) ? MAX : r_cnt + 8'd1;
    // A changed sample re-arms the one-shot in the same edge, which lets
    // STABLE_CYC=1 capture on the very first differing sample.
    assign w_done_eff = w_same & r_done;
    assign w_sel      = ~dig_sel_n;
    assign w_onehot   = (w_sel != '0) &&
                        ((w_sel & (w_sel - NDIG'(1))) == '0);
    assign w_cap      = (w_cnt_nxt == MAX) && !w_done_eff && w_onehot;
    assign w_dec      = dec(seg_in);
    assign w_xfer     = r_valid & frame_ready;

    always_comb begin
        w_idx = 3'd0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            if (w_sel[i]) w_idx = 3'(i);
        end
    end

    always_comb begin
        w_wdig = r_wdig;
        w_werr = r_werr;
        w_wdp  = r_wdp;
        w_seen = r_seen;
        if (w_cap) begin
            w_wdig[4*w_idx +: 4] = w_dec[3:0];
            w_werr[w_idx]        = w_dec[4];
            w_wdp[w_idx]         = w_dp_bit;
            w_seen[w_idx]        = 1'b1;
        end
    end

    assign w_full = &w_seen;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s     <= '1;
            r_cnt   <= 8'd0;
            r_done  <= 1'b0;
            r_seen  <= '0;
            r_wdig  <= '0;
            r_werr  <= '0;
            r_wdp   <= '0;
            r_odig  <= '0;
            r_oerr  <= '0;
            r_odp   <= '0;
            r_ovr   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_s    <= w_port;
            r_cnt  <= w_cnt_nxt;
            r_done <= w_done_eff | w_cap;
            r_wdig <= w_wdig;
            r_werr <= w_werr;
            r_wdp  <= w_wdp;
            r_seen <= w_full ? '0 : w_seen;
            if (w_full) begin
                if (!r_valid || w_xfer) begin
                    r_odig  <= w_wdig;
                    r_oerr  <= w_werr;
                    r_odp   <= w_wdp;
                    r_ovr   <= 1'b0;
                    r_valid <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign frame_digits = r_odig;
    assign frame_err    = r_oerr;
    assign frame_dp     = r_odp;
    assign frame_ovr    = r_ovr;
    assign frame_valid  = r_valid;

endmodule
